// File: rtl/sram_row_ctrl.sv
// ============================================================================
// Module  : sram_row_ctrl
// Purpose : Request sequencer for a ROWS x WIDTH latch-based SRAM bitcell array.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_row_ctrl #(
    parameter int WIDTH     = 8,
    parameter int AW        = 2,
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req,
    input  logic                      we,
    input  logic [AW-1:0]             addr,
    input  logic [WIDTH-1:0]          wdata,
    output logic                      busy,
    output logic                      ack,
    output logic [WIDTH-1:0]          rdata,
    output logic                      cell_r_w,
    output logic [(2**AW)-1:0]        cell_sel,
    output logic [WIDTH-1:0]          cell_in,
    input  logic [(2**AW)*WIDTH-1:0]  cell_out
);

    localparam int ROWS    = 2**AW;
    localparam int WR_N    = (WR_CYCLES < 1) ? 1 : WR_CYCLES;
    localparam int RD_N    = (RD_CYCLES < 1) ? 1 : RD_CYCLES;
    localparam int CNT_MAX = (WR_N > RD_N) ? WR_N : RD_N;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] WR_LOAD = CW'(WR_N - 1);
    localparam logic [CW-1:0] RD_LOAD = CW'(RD_N - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_W_SETUP = 3'd1;
    localparam logic [2:0] S_W_PULSE = 3'd2;
    localparam logic [2:0] S_W_HOLD  = 3'd3;
    localparam logic [2:0] S_R_PULSE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]       state_q,    state_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic [AW-1:0]    addr_q,     addr_d;
    logic [WIDTH-1:0] rdata_q,    rdata_d;
    logic             busy_q,     busy_d;
    logic             ack_q,      ack_d;
    logic             cell_r_w_q, cell_r_w_d;
    logic [ROWS-1:0]  cell_sel_q, cell_sel_d;
    logic [WIDTH-1:0] cell_in_q,  cell_in_d;

    logic [WIDTH-1:0] row_data [ROWS];
    logic [WIDTH-1:0] sel_row_data;
    logic [ROWS-1:0]  req_onehot;
    logic [ROWS-1:0]  addr_onehot;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign row_data[r] = cell_out[r*WIDTH +: WIDTH];
    end

    assign sel_row_data = row_data[addr_q];
    assign req_onehot   = ROWS'(1) << addr;
    assign addr_onehot  = ROWS'(1) << addr_q;

    // Every output flop is loaded with its next-state value, so the cell
    // lines change only on clock edges and never combinationally from the host.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        cell_r_w_d = cell_r_w_q;
        cell_sel_d = cell_sel_q;
        cell_in_d  = cell_in_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d = addr;
                    busy_d = 1'b1;
                    if (we) begin
                        state_d    = S_W_SETUP;
                        cell_r_w_d = 1'b1;
                        cell_in_d  = wdata;
                        cell_sel_d = '0;
                    end else begin
                        state_d    = S_R_PULSE;
                        cnt_d      = RD_LOAD;
                        cell_r_w_d = 1'b0;
                        cell_sel_d = req_onehot;
                    end
                end
            end
            S_W_SETUP: begin
                state_d    = S_W_PULSE;
                cnt_d      = WR_LOAD;
                cell_sel_d = addr_onehot;
            end
            S_W_PULSE: begin
                if (cnt_q == '0) begin
                    state_d    = S_W_HOLD;
                    cell_sel_d = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_W_HOLD: begin
                state_d    = S_DONE;
                cell_r_w_d = 1'b0;
                ack_d      = 1'b1;
            end
            S_R_PULSE: begin
                if (cnt_q == '0) begin
                    state_d    = S_DONE;
                    cell_sel_d = '0;
                    // cells drive an active-low output
                    rdata_d    = ~sel_row_data;
                    ack_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                busy_d     = 1'b0;
                cell_sel_d = '0;
                cell_r_w_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            cell_r_w_q <= 1'b0;
            cell_sel_q <= '0;
            cell_in_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            cell_r_w_q <= cell_r_w_d;
            cell_sel_q <= cell_sel_d;
            cell_in_q  <= cell_in_d;
        end
    end

    assign busy     = busy_q;
    assign ack      = ack_q;
    assign rdata    = rdata_q;
    assign cell_r_w = cell_r_w_q;
    assign cell_sel = cell_sel_q;
    assign cell_in  = cell_in_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_row_ctrl.sv
// ============================================================================
// Module  : tb_sram_row_ctrl
// Purpose : Bench for sram_row_ctrl with behavioural latch cells, default and 3/2 timing.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_row_ctrl;

    localparam int WR1 = 3;
    localparam int RD1 = 2;
    localparam logic [7:0] INIT [4] = '{8'h96, 8'h5A, 8'h71, 8'hE8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0_n = 1'b1, rst1_n = 1'b1;
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [1:0]  addr0 = 0, addr1 = 0;
    logic [7:0]  wdata0 = 0, wdata1 = 0;
    logic        busy0, ack0, rw0, busy1, ack1, rw1;
    logic [7:0]  rdata0, in0, rdata1, in1;
    logic [3:0]  sel0, sel1;
    logic [31:0] cout0, cout1;

    sram_row_ctrl dut0 (
        .clk(clk), .rst_n(rst0_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .busy(busy0), .ack(ack0), .rdata(rdata0), .cell_r_w(rw0), .cell_sel(sel0),
        .cell_in(in0), .cell_out(cout0)
    );

    sram_row_ctrl #(.WR_CYCLES(WR1), .RD_CYCLES(RD1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .busy(busy1), .ack(ack1), .rdata(rdata1), .cell_r_w(rw1), .cell_sel(sel1),
        .cell_in(in1), .cell_out(cout1)
    );

    // Behavioural latch cells: transparent while selected in write mode, inverted read output.
    logic [7:0] cmem0 [4] = INIT;
    logic [7:0] cmem1 [4] = INIT;

    always @(negedge clk) begin
        for (int r = 0; r < 4; r++) begin
            if (sel0[r] && rw0) cmem0[r] = in0;
            if (sel1[r] && rw1) cmem1[r] = in1;
        end
    end

    always_comb begin
        cout0 = '1;
        cout1 = '1;
        for (int r = 0; r < 4; r++) begin
            if (sel0[r] && !rw0) cout0[r*8 +: 8] = ~cmem0[r];
            if (sel1[r] && !rw1) cout1[r*8 +: 8] = ~cmem1[r];
        end
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] ref_mem [2][4];
    logic [7:0] last_rd [2];

    // Select/read-write invariant monitor.
    int inv_err0 = 0, inv_err1 = 0;
    logic p_rw0 = 0, p_rw1 = 0, p_ok0 = 0, p_ok1 = 0;
    logic [3:0] p_sel0 = 0, p_sel1 = 0;
    always @(negedge clk) begin
        if (rst0_n) begin
            if (p_ok0 && (rw0 != p_rw0) && (sel0 != 0 || p_sel0 != 0)) inv_err0++;
            if ($countones(sel0) > 1) inv_err0++;
        end
        if (rst1_n) begin
            if (p_ok1 && (rw1 != p_rw1) && (sel1 != 0 || p_sel1 != 0)) inv_err1++;
            if ($countones(sel1) > 1) inv_err1++;
        end
        p_ok0 = rst0_n; p_rw0 = rw0; p_sel0 = sel0;
        p_ok1 = rst1_n; p_rw1 = rw1; p_sel1 = sel1;
    end

    task automatic drive(input int d, input logic r, input logic w, input int a, input logic [7:0] wd);
        if (d == 0) begin req0 = r; we0 = w; addr0 = a[1:0]; wdata0 = wd; end
        else        begin req1 = r; we1 = w; addr1 = a[1:0]; wdata1 = wd; end
    endtask

    // Issues one request and observes the transaction cycle by cycle (k=1 is the cycle after E0).
    task automatic op(input int d, input logic w, input int a, input logic [7:0] wd, input bit intf,
                      output int lat, output int selw, output int first_sel, output int last_sel,
                      output int stray, output logic busy_pre, output logic rw_first,
                      output logic [7:0] rd);
        logic [3:0] oh, s;
        logic       ak;
        oh = 4'b0001 << a;
        lat = -1; selw = 0; first_sel = -1; last_sel = -1; stray = 0; rd = 'x; rw_first = 'x;
        @(negedge clk);
        busy_pre = (d == 0) ? busy0 : busy1;
        drive(d, 1'b1, w, a, wd);
        @(negedge clk);
        drive(d, 1'b0, w, a, wd);
        for (int k = 1; k <= 30; k++) begin
            s  = (d == 0) ? sel0 : sel1;
            ak = (d == 0) ? ack0 : ack1;
            if (k == 1) rw_first = (d == 0) ? rw0 : rw1;
            if (s == oh) begin
                selw++;
                if (first_sel < 0) first_sel = k;
                last_sel = k;
            end else if (s != 0) begin
                stray++;
            end
            if (intf && k == 2) drive(d, 1'b1, 1'b0, 1, 8'h00);
            if (ak) begin
                lat = k;
                rd  = (d == 0) ? rdata0 : rdata1;
                break;
            end
            @(negedge clk);
        end
        drive(d, 1'b0, 1'b0, 0, 8'h00);
    endtask

    task automatic test_reset();
        #1 rst0_n = 1'b0; rst1_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy0, ack0, rdata0, rw0, sel0, in0} !== '0) begin
            errors++;
            $display("FAIL reset_dut0: busy=%b ack=%b rdata=%h rw=%b sel=%b in=%h want all zero",
                     busy0, ack0, rdata0, rw0, sel0, in0);
        end
        checks++;
        if ({busy1, ack1, rdata1, rw1, sel1, in1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1: busy=%b ack=%b rdata=%h rw=%b sel=%b in=%h want all zero",
                     busy1, ack1, rdata1, rw1, sel1, in1);
        end
        rst0_n = 1'b1; rst1_n = 1'b1;
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    endtask

    task automatic test_write_basic();
        int lat, sw, fs, ls, st; logic bp, rwf; logic [7:0] rd;
        op(0, 1'b1, 2, 8'hA5, 0, lat, sw, fs, ls, st, bp, rwf, rd);
        ref_mem[0][2] = 8'hA5;
        checks++; if (lat !== 5) begin errors++; $display("FAIL wr_latency: got %0d want 5", lat); end
        checks++; if (sw !== 2 || fs !== 2 || ls !== 3) begin
            errors++; $display("FAIL wr_sel_window: width=%0d first=%0d last=%0d want 2/2/3", sw, fs, ls); end
        checks++; if (rwf !== 1'b1 || st !== 0) begin
            errors++; $display("FAIL wr_setup: rw=%b stray=%0d want rw=1 stray=0", rwf, st); end
        checks++; if (rd !== last_rd[0]) begin
            errors++; $display("FAIL wr_keeps_rdata: got %h want %h", rd, last_rd[0]); end
        checks++; if (cmem0[2] !== 8'hA5) begin
            errors++; $display("FAIL wr_cell_content: got %h want a5", cmem0[2]); end
    endtask

    task automatic test_read_basic();
        int lat, sw, fs, ls, st; logic bp, rwf; logic [7:0] rd;
        op(0, 1'b0, 2, 8'h00, 0, lat, sw, fs, ls, st, bp, rwf, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", lat); end
        checks++; if (sw !== 1 || fs !== 1 || st !== 0) begin
            errors++; $display("FAIL rd_sel_window: width=%0d first=%0d stray=%0d want 1/1/0", sw, fs, st); end
        checks++; if (rd !== ref_mem[0][2]) begin
            errors++; $display("FAIL rd_data: got %h want %h", rd, ref_mem[0][2]); end
        last_rd[0] = ref_mem[0][2];
    endtask

    task automatic test_back_to_back();
        int lat, sw, fs, ls, st; logic bp, rwf; logic [7:0] rd;
        logic       w  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int         a  [4] = '{0, 3, 0, 3};
        logic [7:0] wd [4] = '{8'h3C, 8'hC3, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            op(0, w[i], a[i], wd[i], 0, lat, sw, fs, ls, st, bp, rwf, rd);
            checks++; if (bp !== 1'b0 || lat !== (w[i] ? 5 : 2) || st !== 0) begin
                errors++; $display("FAIL b2b_%0d: busy_pre=%b lat=%0d stray=%0d want 0/%0d/0",
                                   i, bp, lat, st, w[i] ? 5 : 2); end
            if (w[i]) ref_mem[0][a[i]] = wd[i];
            else begin
                checks++; if (rd !== ref_mem[0][a[i]]) begin
                    errors++; $display("FAIL b2b_rdata_%0d: got %h want %h", i, rd, ref_mem[0][a[i]]); end
                last_rd[0] = ref_mem[0][a[i]];
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat, sw, fs, ls, st, extra; logic bp, rwf; logic [7:0] rd;
        op(0, 1'b1, 2, 8'h11, 1, lat, sw, fs, ls, st, bp, rwf, rd);
        ref_mem[0][2] = 8'h11;
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ack0 || sel0 != 0) extra++;
        end
        checks++; if (lat !== 5 || st !== 0) begin
            errors++; $display("FAIL busy_req_stray: lat=%0d stray=%0d want 5/0", lat, st); end
        checks++; if (extra !== 0 || busy0 !== 1'b0) begin
            errors++; $display("FAIL busy_req_ignored: extra=%0d busy=%b want 0/0", extra, busy0); end
        op(0, 1'b0, 1, 8'h00, 0, lat, sw, fs, ls, st, bp, rwf, rd);
        checks++; if (rd !== ref_mem[0][1]) begin
            errors++; $display("FAIL busy_row1_intact: got %h want %h", rd, ref_mem[0][1]); end
        last_rd[0] = ref_mem[0][1];
    endtask

    task automatic test_reset_mid_write();
        int lat, sw, fs, ls, st; logic bp, rwf; logic [7:0] rd;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 3, 8'h42);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 0, 8'h00);
        repeat (2) @(negedge clk);
        checks++; if (sel0 !== 4'b1000) begin
            errors++; $display("FAIL rst_mid_pulse_sel: got %b want 1000", sel0); end
        rst0_n = 1'b0;
        #1;
        checks++; if (sel0 !== 4'b0000 || busy0 !== 1'b0 || rdata0 !== 8'h00 || rw0 !== 1'b0) begin
            errors++; $display("FAIL rst_async: sel=%b busy=%b rdata=%h rw=%b want 0/0/00/0",
                               sel0, busy0, rdata0, rw0); end
        // the behavioural cells latched the data during the first pulse cycle
        ref_mem[0][3] = 8'h42;
        last_rd[0] = 8'h00;
        @(negedge clk);
        rst0_n = 1'b1;
        op(0, 1'b0, 1, 8'h00, 0, lat, sw, fs, ls, st, bp, rwf, rd);
        checks++; if (lat !== 2 || rd !== ref_mem[0][1]) begin
            errors++; $display("FAIL rst_untouched_row: lat=%0d rdata=%h want 2/%h", lat, rd, ref_mem[0][1]); end
        last_rd[0] = ref_mem[0][1];
    endtask

    task automatic test_slow_timing();
        int lat, sw, fs, ls, st; logic bp, rwf; logic [7:0] rd;
        logic [7:0] wd;
        int a;
        a  = $urandom_range(0, 3);
        wd = 8'($urandom);
        op(1, 1'b1, a, wd, 0, lat, sw, fs, ls, st, bp, rwf, rd);
        ref_mem[1][a] = wd;
        checks++; if (lat !== WR1 + 3 || sw !== WR1 || fs !== 2 || st !== 0) begin
            errors++; $display("FAIL slow_write: lat=%0d width=%0d first=%0d stray=%0d want %0d/%0d/2/0",
                               lat, sw, fs, st, WR1 + 3, WR1); end
        op(1, 1'b0, a, 8'h00, 0, lat, sw, fs, ls, st, bp, rwf, rd);
        checks++; if (lat !== RD1 + 1 || sw !== RD1 || rd !== wd) begin
            errors++; $display("FAIL slow_read: lat=%0d width=%0d rdata=%h want %0d/%0d/%h",
                               lat, sw, rd, RD1 + 1, RD1, wd); end
        last_rd[1] = wd;
    endtask

    task automatic test_random();
        int lat, sw, fs, ls, st, d, a, el, ew; logic bp, rwf, w; logic [7:0] rd, wd, er;
        for (int i = 0; i < 40; i++) begin
            d  = $urandom_range(0, 1);
            w  = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, 3);
            wd = 8'($urandom);
            op(d, w, a, wd, 0, lat, sw, fs, ls, st, bp, rwf, rd);
            el = w ? ((d == 0 ? 2 : WR1) + 3) : ((d == 0 ? 1 : RD1) + 1);
            ew = w ? (d == 0 ? 2 : WR1) : (d == 0 ? 1 : RD1);
            er = w ? last_rd[d] : ref_mem[d][a];
            checks++; if (lat !== el || sw !== ew || st !== 0 || rd !== er) begin
                errors++; $display("FAIL rand_%0d dut%0d we=%b row=%0d: lat=%0d width=%0d stray=%0d rdata=%h want %0d/%0d/0/%h",
                                   i, d, w, a, lat, sw, st, rd, el, ew, er); end
            if (w) ref_mem[d][a] = wd;
            else   last_rd[d]    = er;
        end
    endtask

    task automatic test_invariants();
        checks++; if (inv_err0 !== 0) begin
            errors++; $display("FAIL invariants_dut0: violations=%0d want 0", inv_err0); end
        checks++; if (inv_err1 !== 0) begin
            errors++; $display("FAIL invariants_dut1: violations=%0d want 0", inv_err1); end
    endtask

    initial begin
        for (int r = 0; r < 4; r++) begin
            ref_mem[0][r] = INIT[r];
            ref_mem[1][r] = INIT[r];
        end
        test_reset();
        test_write_basic();
        test_read_basic();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_write();
        test_slow_timing();
        test_random();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
